// File: rtl/rf_sb_pkg.sv
// rf_sb_pkg: shared constants and the saturating counter update for the
// register-file scoreboard.
package rf_sb_pkg;

  localparam int unsigned NUM_ARCH_REGS = 15;
  localparam logic [3:0]  PC_IDX        = 4'hF;

  // Widest counter the shared update function supports.
  localparam int unsigned SB_MAXW = 8;

  typedef struct packed {
    logic [SB_MAXW-1:0] count;
    logic               err;
  } sat_res_t;

  // count + inc - dec, clamped to [0, max]; err flags any clamp.
  function automatic sat_res_t sat_update(input logic [SB_MAXW-1:0] count,
                                          input logic [1:0]         inc,
                                          input logic [1:0]         dec,
                                          input logic [SB_MAXW-1:0] max);
    logic [SB_MAXW:0] sum;
    sat_res_t         r;
    r.count = '0;
    r.err   = 1'b0;
    sum     = {1'b0, count} + (SB_MAXW+1)'(inc);
    if ((SB_MAXW+1)'(dec) > sum) begin
      r.err = 1'b1;
    end else begin
      sum = sum - (SB_MAXW+1)'(dec);
      if (sum > {1'b0, max}) begin
        r.count = max;
        r.err   = 1'b1;
      end else begin
        r.count = sum[SB_MAXW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_sb_counter.sv
// rf_sb_counter: one per-register pending-write counter with saturation,
// synchronous clear and a per-cycle protocol-error output.
module rf_sb_counter
  import rf_sb_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [SB_MAXW-1:0] MAX = SB_MAXW'((1 << CNT_W) - 1);

  sat_res_t res;
  logic     unused_hi;

  // Next count and clamp detection from the shared update.
  always_comb begin
    res = sat_update(SB_MAXW'(count), inc, dec, MAX);
  end

  // Upper bits are always zero because the result is clamped to MAX.
  assign unused_hi = ^res.count[SB_MAXW-1:CNT_W];

  // A clearing cycle discards inc/dec, so it cannot report an error.
  assign err = ~clr & res.err;

  // Counter register: reset and clear both zero it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= res.count[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: tracks in-flight writes to R0..R14 and stalls decode on
// RAW hazards or saturated destination counters. R15 (PC) is never tracked.
// Optional: RF_SB_WB_BYPASS_EN lets a same-cycle writeback of the last
// pending write clear a source hazard immediately.
module rf_scoreboard
  import rf_sb_pkg::*;
#(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned NREG  = NUM_ARCH_REGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [3:0]      dec_ra1,
  input  logic [3:0]      dec_ra2,
  input  logic [3:0]      dec_ra3,
  input  logic            dec_use1,
  input  logic            dec_use2,
  input  logic            dec_use3,
  input  logic            dec_we3,
  input  logic            dec_we1,
  input  logic [3:0]      dec_wa3,
  input  logic [3:0]      dec_wa1,
  input  logic            wb_we3,
  input  logic            wb_we1,
  input  logic [3:0]      wb_wa3,
  input  logic [3:0]      wb_wa1,
  input  logic            flush,
  output logic            stall,
  output logic            issue,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  logic [NREG-1:0] src_hz;
  logic [NREG-1:0] dst_full;
  logic [NREG-1:0] cnt_err;

  // Indices stop at NREG-1, so R15 (PC_IDX) never matches any counter.
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    logic             dst3, dst1, wb3, wb1, rd, full, byp;
    logic [1:0]       inc, dec;

    assign dst3 = dec_we3 & (dec_wa3 == 4'(g));
    assign dst1 = dec_we1 & (dec_wa1 == 4'(g));
    assign wb3  = wb_we3 & (wb_wa3 == 4'(g));
    assign wb1  = wb_we1 & (wb_wa1 == 4'(g));
    assign rd   = (dec_use1 & (dec_ra1 == 4'(g))) |
                  (dec_use2 & (dec_ra2 == 4'(g))) |
                  (dec_use3 & (dec_ra3 == 4'(g)));
    assign full = (cnt == '1);

`ifdef RF_SB_WB_BYPASS_EN
    assign byp = (cnt == CNT_W'(1)) & (wb3 | wb1);
`else
    assign byp = 1'b0;
`endif

    assign src_hz[g]   = rd & busy_vec[g] & ~byp;
    assign dst_full[g] = (dst3 | dst1) & full;
    assign inc         = issue ? (2'(dst3) + 2'(dst1)) : 2'b00;
    assign dec         = 2'(wb3) + 2'(wb1);
    assign busy_vec[g] = (cnt != '0);

    rf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (inc),
      .dec   (dec),
      .count (cnt),
      .err   (cnt_err[g])
    );
  end

  assign stall = dec_valid & ((|src_hz) | (|dst_full));
  assign issue = dec_valid & ~stall;

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (|cnt_err) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: sequential directed vector table plus a short
// hand-written RAW sequence on the port-1 / ra3 paths.
module tb_rf_scoreboard;

`ifdef RF_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset, flush, dec_valid;
  logic [3:0]  dec_ra1, dec_ra2, dec_ra3;
  logic        dec_use1, dec_use2, dec_use3;
  logic        dec_we3, dec_we1;
  logic [3:0]  dec_wa3, dec_wa1;
  logic        wb_we3, wb_we1;
  logic [3:0]  wb_wa3, wb_wa1;
  logic        stall, issue, err;
  logic [14:0] busy_vec;

  int checks;
  int failures;

  rf_scoreboard #(.CNT_W(2), .NREG(15)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_ra3(dec_ra3),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_use3(dec_use3),
    .dec_we3(dec_we3), .dec_we1(dec_we1),
    .dec_wa3(dec_wa3), .dec_wa1(dec_wa1),
    .wb_we3(wb_we3), .wb_we1(wb_we1),
    .wb_wa3(wb_wa3), .wb_wa1(wb_wa1),
    .flush(flush), .stall(stall), .issue(issue),
    .busy_vec(busy_vec), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, dv;
    logic [3:0]  r1, r2, r3;
    logic [2:0]  u;
    logic        w3;
    logic [3:0]  a3;
    logic        w1;
    logic [3:0]  a1;
    logic        bw3;
    logic [3:0]  ba3;
    logic        bw1;
    logic [3:0]  ba1;
    logic        es, ei;
    logic [14:0] eb;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, fl, dv,
                              input logic [3:0] r1, r2, r3, input logic [2:0] u,
                              input logic w3, input logic [3:0] a3,
                              input logic w1, input logic [3:0] a1,
                              input logic bw3, input logic [3:0] ba3,
                              input logic bw1, input logic [3:0] ba1,
                              input logic es, ei, input logic [14:0] eb,
                              input logic ee);
    vec_t v;
    v.rst = rst; v.fl = fl; v.dv = dv;
    v.r1 = r1; v.r2 = r2; v.r3 = r3; v.u = u;
    v.w3 = w3; v.a3 = a3; v.w1 = w1; v.a1 = a1;
    v.bw3 = bw3; v.ba3 = ba3; v.bw1 = bw1; v.ba1 = ba1;
    v.es = es; v.ei = ei; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; flush = v.fl; dec_valid = v.dv;
    dec_ra1 = v.r1; dec_ra2 = v.r2; dec_ra3 = v.r3;
    dec_use1 = v.u[0]; dec_use2 = v.u[1]; dec_use3 = v.u[2];
    dec_we3 = v.w3; dec_wa3 = v.a3; dec_we1 = v.w1; dec_wa1 = v.a1;
    wb_we3 = v.bw3; wb_wa3 = v.ba3; wb_we1 = v.bw1; wb_wa1 = v.ba1;
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    failures = 0;
    idle = mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 15'h0,0);
    drive(idle);

    // Reset, then RAW on R3 via port 3
    vecs.push_back(mk(1,0,0, 0,0,0,0,     0,0,0,0, 0,0,0,0, 0,0, 15'h0000,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0,     1,3,0,0, 0,0,0,0, 0,1, 15'h0008,0));
    vecs.push_back(mk(0,0,1, 3,0,0,3'b001,0,0,0,0, 0,0,0,0, 1,0, 15'h0008,0));
    vecs.push_back(mk(0,0,1, 3,0,0,3'b001,0,0,0,0, 1,3,0,0,
                      BYP ? 1'b0 : 1'b1, BYP ? 1'b1 : 1'b0, 15'h0000,0));
    vecs.push_back(mk(0,0,1, 3,0,0,3'b001,0,0,0,0, 0,0,0,0, 0,1, 15'h0000,0));
    // Saturation on R7
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,1, 0,0,0,0, 1,7,0,0, 0,0,0,0, 0,1, 15'h0080,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,7,0,0, 0,0,0,0, 1,0, 15'h0080,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,7,0,0, 0,0,1,7, 1,0, 15'h0080,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,7,0,0, 0,0,0,0, 0,1, 15'h0080,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 1,7,1,7, 0,0, 15'h0080,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1,7, 0,0, 15'h0000,0));
    // Dual port with same-cycle writeback to R1
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,1,0,0, 0,0,0,0, 0,1, 15'h0002,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,1,1,4, 1,1,0,0, 0,1, 15'h0012,0));
    // R15 ignored as source and destination
    vecs.push_back(mk(0,0,1, 0,15,0,3'b010, 1,15,0,0, 0,0,0,0, 0,1, 15'h0012,0));
    vecs.push_back(mk(0,0,1, 0,4,0,3'b010,  0,0,0,0,  0,0,0,0, 1,0, 15'h0012,0));
    vecs.push_back(mk(0,0,1, 0,0,1,3'b100,  0,0,0,0,  0,0,0,0, 1,0, 15'h0012,0));
    // Reset mid-operation with R2=1, R5=2 (R1, R4 also busy)
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,2,1,5, 0,0,0,0, 0,1, 15'h0036,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,1,5, 0,0,0,0, 0,1, 15'h0036,0));
    vecs.push_back(mk(1,1,1, 0,0,0,0, 1,2,0,0, 0,0,0,0, 0,1, 15'h0000,0));
    vecs.push_back(mk(0,0,1, 5,0,0,3'b001, 0,0,0,0, 0,0,0,0, 0,1, 15'h0000,0));
    // Flush masks an underflowing writeback; then a real underflow
    vecs.push_back(mk(0,1,0, 0,0,0,0, 0,0,0,0, 0,0,1,9, 0,0, 15'h0000,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,1,9, 0,0, 15'h0000,1));
    vecs.push_back(idle_err(1'b1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 15'h0000,0));
    // Overflow: dual destination R6 at count 2 -> saturate at 3, err
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,6,0,0, 0,0,0,0, 0,1, 15'h0040,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,6,0,0, 0,0,0,0, 0,1, 15'h0040,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,6,1,6, 0,0,0,0, 0,1, 15'h0040,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,1,6, 0,0,0,0, 1,0, 15'h0040,1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 15'h0000,0));
    // Fill R0..R13 two per cycle, then R14 overflow sets err
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0,0,1, 0,0,0,0, 1,4'(2*k),1,4'(2*k+1), 0,0,0,0, 0,1,
                        15'((1 << (2*k+2)) - 1), 0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,14,1,14, 0,0,0,0, 0,1, 15'h7FFF,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,14,1,14, 0,0,0,0, 0,1, 15'h7FFF,1));
    // Flush with same-cycle issue and writebacks
    vecs.push_back(mk(0,1,1, 0,0,0,0, 1,0,0,0, 1,5,1,3, 0,1, 15'h0000,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,14,1,14, 0,0,0,0, 0,1, 15'h4000,1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("stall", i, 32'(stall), 32'(vecs[i].es));
      chk("issue", i, 32'(issue), 32'(vecs[i].ei));
      @(posedge clk);
      #1;
      chk("busy_vec", i, 32'(busy_vec), 32'(vecs[i].eb));
      chk("err", i, 32'(err), 32'(vecs[i].ee));
    end

    // Hand sequence: reset, write R8 on port 1, read it on ra3, retire on port 1
    @(negedge clk); drive(idle); reset = 1'b1;
    @(negedge clk); drive(idle); dec_valid = 1'b1; dec_we1 = 1'b1; dec_wa1 = 4'd8;
    #1 chk("seq_issue_w1", 100, 32'(issue), 32'd1);
    @(negedge clk); drive(idle); dec_valid = 1'b1; dec_use3 = 1'b1; dec_ra3 = 4'd8;
    #1 chk("seq_raw_stall", 101, 32'(stall), 32'd1);
    chk("seq_busy8", 101, 32'(busy_vec), 32'h100);
    @(negedge clk); wb_we1 = 1'b1; wb_wa1 = 4'd8;
    #1 chk("seq_wb_cycle", 102, 32'(stall), BYP ? 32'd0 : 32'd1);
    @(negedge clk); wb_we1 = 1'b0;
    #1 chk("seq_after_wb", 103, 32'(stall), 32'd0);
    chk("seq_busy_clr", 103, 32'(busy_vec), 32'h0);
    chk("seq_err", 103, 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic vec_t idle_err(input logic e);
    return mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 15'h0000, e);
  endfunction

endmodule
